// File: rtl/execute_muldiv_if.sv
// Execute-stage <-> mul/div sequencer handshake bundle.
// Latency: none (wires only).
// Backpressure: StallMD from the sequencer holds the issuing stages.
interface execute_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic [2:0]       MulDivOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             FlushE;
  logic             StallMD;
  logic             DoneE;
  logic [WIDTH-1:0] MulDivResultE;

  // Execute stage side: issues the op and consumes the result.
  modport master (
    output StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    input  StallMD, DoneE, MulDivResultE
  );

  // Sequencer side.
  modport slave (
    input  StartE, MulDivOpE, SrcAE, SrcBE, FlushE,
    output StallMD, DoneE, MulDivResultE
  );
endinterface

// File: rtl/execute_muldiv_ctrl.sv
// RV32M multi-cycle sequencer: shift-add multiply / restoring divide on operand magnitudes.
// Latency: WIDTH+1 stall cycles then a one-cycle DoneE; divide-by-zero/overflow: 1 stall cycle then DoneE.
// Backpressure: StallMD holds F/D/E from the issue cycle through the last iteration; FlushE aborts.
module execute_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  execute_muldiv_if.slave    md
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  // Multiply: {product_hi, multiplier/product_lo}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opb_q;       // multiplicand or divisor magnitude
  logic [2:0]         op_q;
  logic               sign_res_q;  // product/quotient must be negated
  logic               sign_rem_q;  // remainder must be negated
  logic               done_q;
  logic [WIDTH-1:0]   result_q;

  // Issue-time operand decode
  logic             is_div, a_signed, b_signed, neg_a, neg_b;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_res;

  assign is_div   = md.MulDivOpE[2];
  assign a_signed = is_div ? ~md.MulDivOpE[0] : (md.MulDivOpE != 3'b011);
  assign b_signed = is_div ? ~md.MulDivOpE[0] : ~md.MulDivOpE[1];
  assign neg_a    = a_signed & md.SrcAE[WIDTH-1];
  assign neg_b    = b_signed & md.SrcBE[WIDTH-1];
  assign mag_a    = neg_a ? -md.SrcAE : md.SrcAE;
  assign mag_b    = neg_b ? -md.SrcBE : md.SrcBE;
  assign div_zero = is_div & (md.SrcBE == '0);
  assign div_ovf  = is_div & ~md.MulDivOpE[0] &
                    (md.SrcAE == {1'b1, {(WIDTH-1){1'b0}}}) & (md.SrcBE == '1);
  // x/0: quotient all-ones, remainder = dividend. MIN/-1: quotient MIN, remainder 0.
  assign special_res = div_zero ? (md.MulDivOpE[1] ? md.SrcAE : '1)
                                : (md.MulDivOpE[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});

  // One iteration of the datapath
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, acc_next, prod;
  logic [WIDTH-1:0]   quo, rem, final_res;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  // Remainder stays below the divisor, so a borrow shows up as bit WIDTH of the difference.
  assign div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
  assign acc_next  = op_q[2] ? div_next : mul_next;

  assign prod = sign_res_q ? -acc_next : acc_next;
  assign quo  = acc_next[WIDTH-1:0];
  assign rem  = acc_next[2*WIDTH-1:WIDTH];

  // Sign fix-up and result select on the final iteration's value
  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         final_res = sign_res_q ? -quo : quo;
      default:                final_res = sign_rem_q ? -rem : rem;
    endcase
  end

  // Sequencer FSM with registered DoneE/result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      op_q       <= '0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md.StartE && !md.FlushE) begin
            op_q       <= md.MulDivOpE;
            sign_res_q <= neg_a ^ neg_b;
            sign_rem_q <= neg_a;
            opb_q      <= mag_b;
            acc_q      <= {{WIDTH{1'b0}}, mag_a};
            cnt_q      <= '0;
            if (div_zero || div_ovf) begin
              result_q <= special_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (md.FlushE) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_next;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
              result_q <= final_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.StallMD       = ((state_q == IDLE) & md.StartE & ~md.FlushE) | (state_q == BUSY);
  assign md.DoneE         = done_q;
  assign md.MulDivResultE = result_q;

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// Directed bench for execute_muldiv_ctrl: vector table plus flush/reset/back-to-back sequences.
module tb_execute_muldiv_ctrl;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  execute_muldiv_if #(.WIDTH(32)) md_if ();

  execute_muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          stall;
    string       name;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic set_vec(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp,
                         input int stall, input string name);
    vecs[i].op = op; vecs[i].a = a; vecs[i].b = b;
    vecs[i].exp = exp; vecs[i].stall = stall; vecs[i].name = name;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge-aligned time; drives the op and follows it to DoneE.
  task automatic run_op(input vec_t v, input bit hold);
    int          stall;
    bit          got;
    logic [31:0] res;
    md_if.MulDivOpE = v.op;
    md_if.SrcAE     = v.a;
    md_if.SrcBE     = v.b;
    md_if.FlushE    = 1'b0;
    md_if.StartE    = 1'b1;
    stall = 0;
    got   = 1'b0;
    res   = '0;
    for (int c = 0; c < 60 && !got; c++) begin
      #1;
      if (md_if.DoneE) begin
        got = 1'b1;
        res = md_if.MulDivResultE;
        check({v.name, ":stall_in_done"}, 32'(md_if.StallMD), 32'd0);
      end else begin
        if (md_if.StallMD) stall++;
        @(negedge clk);
      end
    end
    check({v.name, ":done_seen"}, 32'(got), 32'd1);
    check({v.name, ":stall_cycles"}, 32'(stall), 32'(v.stall));
    check({v.name, ":result"}, res, v.exp);
    if (!hold) md_if.StartE = 1'b0;
    @(negedge clk);
    if (!hold) begin
      #1;
      check({v.name, ":idle_stall"}, 32'(md_if.StallMD), 32'd0);
      check({v.name, ":idle_done"}, 32'(md_if.DoneE), 32'd0);
    end
  endtask

  initial begin
    int   done_cnt;
    vec_t v;

    set_vec(0,  3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "MUL_7xm3");
    set_vec(1,  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "MULHU_ff");
    set_vec(2,  3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33, "MULH_m1m1");
    set_vec(3,  3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33, "MULHSU_m1x2");
    set_vec(4,  3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33, "DIV_m7d2");
    set_vec(5,  3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33, "REM_m7d2");
    set_vec(6,  3'b101, 32'd100,      32'd7,        32'd14,       33, "DIVU_100d7");
    set_vec(7,  3'b111, 32'd100,      32'd7,        32'd2,        33, "REMU_100d7");
    set_vec(8,  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  "DIVU_div0");
    set_vec(9,  3'b111, 32'd5,        32'd0,        32'd5,        1,  "REMU_div0");
    set_vec(10, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "DIV_ovf");
    set_vec(11, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  "REM_ovf");
    set_vec(12, 3'b100, 32'd7,        32'd0,        32'hFFFFFFFF, 1,  "DIV_div0");
    set_vec(13, 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1,  "REM_div0");
    set_vec(14, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33, "MULH_min");
    set_vec(15, 3'b000, 32'h12345678, 32'h00000010, 32'h23456780, 33, "MUL_shift");

    rst_n           = 1'b0;
    md_if.StartE    = 1'b0;
    md_if.FlushE    = 1'b0;
    md_if.MulDivOpE = '0;
    md_if.SrcAE     = '0;
    md_if.SrcBE     = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset:stall", 32'(md_if.StallMD), 32'd0);
    check("reset:done", 32'(md_if.DoneE), 32'd0);
    check("reset:result", md_if.MulDivResultE, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven ops
    for (int i = 0; i < NV; i++) run_op(vecs[i], 1'b0);

    // Back-to-back: StartE held high across DONE
    v = vecs[0];  v.name = "B2B_MUL";
    run_op(v, 1'b1);
    v = vecs[4];  v.name = "B2B_DIV";
    run_op(v, 1'b0);

    // Flush at BUSY iteration 10
    md_if.MulDivOpE = 3'b000;
    md_if.SrcAE     = 32'd7;
    md_if.SrcBE     = 32'd9;
    md_if.StartE    = 1'b1;
    repeat (11) @(negedge clk);
    md_if.FlushE = 1'b1;
    #1;
    check("flush:busy_stall", 32'(md_if.StallMD), 32'd1);
    @(negedge clk);
    md_if.FlushE = 1'b0;
    md_if.StartE = 1'b0;
    #1;
    check("flush:idle_stall", 32'(md_if.StallMD), 32'd0);
    check("flush:idle_done", 32'(md_if.DoneE), 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md_if.DoneE) done_cnt++;
    end
    check("flush:no_done", 32'(done_cnt), 32'd0);

    // Reset at BUSY iteration 20; previous result register is nonzero
    md_if.MulDivOpE = 3'b011;
    md_if.SrcAE     = 32'hFFFFFFFF;
    md_if.SrcBE     = 32'hFFFFFFFF;
    md_if.StartE    = 1'b1;
    repeat (21) @(negedge clk);
    rst_n        = 1'b0;
    md_if.StartE = 1'b0;
    @(negedge clk);
    #1;
    check("rst_mid:stall", 32'(md_if.StallMD), 32'd0);
    check("rst_mid:done", 32'(md_if.DoneE), 32'd0);
    check("rst_mid:result", md_if.MulDivResultE, 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (md_if.DoneE) done_cnt++;
    end
    check("rst_mid:no_done", 32'(done_cnt), 32'd0);

    // Recovery after mid-op reset
    v = vecs[7];  v.name = "POST_RST_REMU";
    run_op(v, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
